// File: rtl/rx_frame_packer_if.sv
// rx_frame_packer_if: tagged word stream from the packer
// FIFO to the downstream packet formatter (valid/ready)
interface rx_frame_packer_if #(
  parameter int DW = 16
);
  logic [DW+1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/rx_frame_packer.sv
// rx_frame_packer: gated multi-channel strobe capture,
// tagged serialisation and FWFT buffering (rxclk domain)
module rx_frame_packer #(
  parameter int NCH       = 8,
  parameter int DW        = 16,
  parameter int AW        = 12,
  parameter int PKT_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic               rxclk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               clear_status,
  input  logic               gate_enable,
  input  logic               rxstrobe,
  input  logic [3:0]         channels,
  input  logic [NCH*DW-1:0]  ch_data,
  rx_frame_packer_if.master  rx_out,
  output logic [AW:0]        level,
  output logic               pkt_rdy,
  output logic               overrun,
  output logic [CNT_W-1:0]   drop_count,
  output logic [CNT_W-1:0]   frame_count
);

  localparam int          DEPTH   = 2**AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] PKT_L   = (AW+1)'(PKT_WORDS);
  localparam logic [3:0]  NCH_L   = 4'(NCH);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [3:0]          phase;
  logic [3:0]          n_lat;
  logic [3:0]          n_eff;
  logic [NCH*DW-1:0]   data_lat;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [DW+1:0]       mem [DEPTH];
  logic [AW:0]         free;
  logic [DW-1:0]       sample;
  logic [DW+1:0]       word;
  logic                req;
  logic                admit;
  logic                drop;
  logic                push;
  logic                pop;
  logic                last;
  logic                empty;

  // Frame length clamped to the channels actually wired in
  assign n_eff = (channels > NCH_L) ? NCH_L : channels;
  assign free  = DEPTH_L - level;
  assign req   = rxstrobe & gate_enable &
                 (n_eff != 4'd0) & ~flush;
  assign last  = (phase == n_lat - 4'd1);
  assign empty = (level == '0);
  assign pop   = ~empty & rx_out.out_ready & ~flush;

  // Select the latched channel for the current phase
  always_comb begin
    sample = '0;
    for (int k = 0; k < NCH; k++) begin
      if (phase == 4'(k)) begin
        sample = data_lat[k*DW +: DW];
      end
    end
  end

  assign word = {(phase == 4'd0), ~phase[0], sample};

  // FSM state register
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state: admit whole frames only when space is free
  always_comb begin
    state_n = state;
    admit   = 1'b0;
    drop    = 1'b0;
    push    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (free >= (AW+1)'(n_eff)) begin
            admit   = 1'b1;
            state_n = SEND;
          end else begin
            drop = 1'b1;
          end
        end
      end
      SEND: begin
        push = 1'b1;
        drop = req;
        if (last) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      push    = 1'b0;
    end
  end

  // Phase counter and frame capture
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= '0;
      n_lat    <= '0;
      data_lat <= '0;
    end else if (flush) begin
      phase <= '0;
    end else if (admit) begin
      phase    <= '0;
      n_lat    <= n_eff;
      data_lat <= ch_data;
    end else if (push) begin
      phase <= last ? 4'd0 : phase + 4'd1;
    end
  end

  // FIFO storage; space is reserved so push never hits full
  always_ff @(posedge rxclk) begin
    if (push) begin
      mem[wr_ptr] <= word;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};
    end
  end

  assign rx_out.out_valid = ~empty;
  assign rx_out.out_data  = empty ? '0 : mem[rd_ptr];

  // Packet-ready flag lags level by one cycle
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_rdy <= 1'b0;
    end else begin
      pkt_rdy <= (level >= PKT_L);
    end
  end

  // Sticky overrun, saturating drops, wrapping frames
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      drop_count  <= '0;
      frame_count <= '0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_status) begin
        overrun <= 1'b0;
      end
      if (drop) begin
        if (clear_status) begin
          drop_count <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (drop_count != '1) begin
          drop_count <= drop_count + 1'b1;
        end
      end else if (clear_status) begin
        drop_count <= '0;
      end
      if (admit) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_packer.sv
// tb_rx_frame_packer: directed checks of framing,
// admission, drops, thresholds, flush and reset
module tb_rx_frame_packer;
  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int AW  = 5;
  localparam int PKT = 12;
  localparam int CW  = 16;

  logic              rxclk        = 1'b0;
  logic              reset_n      = 1'b0;
  logic              flush        = 1'b0;
  logic              clear_status = 1'b0;
  logic              gate_enable  = 1'b0;
  logic              rxstrobe     = 1'b0;
  logic [3:0]        channels     = 4'd0;
  logic [NCH*DW-1:0] ch_data;
  logic [AW:0]       level;
  logic              pkt_rdy;
  logic              overrun;
  logic [CW-1:0]     drop_count;
  logic [CW-1:0]     frame_count;

  int errors = 0;
  int checks = 0;

  rx_frame_packer_if #(.DW(DW)) bus ();

  rx_frame_packer #(
    .NCH(NCH), .DW(DW), .AW(AW),
    .PKT_WORDS(PKT), .CNT_W(CW)
  ) dut (
    .rxclk(rxclk),
    .reset_n(reset_n),
    .flush(flush),
    .clear_status(clear_status),
    .gate_enable(gate_enable),
    .rxstrobe(rxstrobe),
    .channels(channels),
    .ch_data(ch_data),
    .rx_out(bus),
    .level(level),
    .pkt_rdy(pkt_rdy),
    .overrun(overrun),
    .drop_count(drop_count),
    .frame_count(frame_count)
  );

  always #5 rxclk = ~rxclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic strobe();
    rxstrobe = 1'b1;
    tick();
    rxstrobe = 1'b0;
  endtask

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ew(int k);
    logic [3:0] kk;
    kk = 4'(k);
    return {(k == 0), ~kk[0], 16'h5A00 + 16'(k)};
  endfunction

  initial begin
    for (int k = 0; k < NCH; k++)
      ch_data[k*DW +: DW] = 16'h5A00 + 16'(k);
    bus.out_ready = 1'b1;

    tick();
    tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_pkt", pkt_rdy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_frame", frame_count, 0);
    chk("rst_data", bus.out_data, 0);

    reset_n     = 1'b1;
    gate_enable = 1'b1;
    tick();

    channels = 4'd4;
    strobe();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("f4_word", bus.out_data, ew(k));
    end
    tick();
    chk("f4_empty", bus.out_valid, 0);
    chk("f4_frames", frame_count, 1);

    channels = 4'd9;
    strobe();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("f9_word", bus.out_data, ew(k));
    end
    tick();
    chk("f9_empty", bus.out_valid, 0);
    chk("f9_frames", frame_count, 2);

    channels = 4'd0;
    strobe();
    tick();
    tick();
    chk("f0_level", level, 0);
    chk("f0_drop", drop_count, 0);
    chk("f0_frames", frame_count, 2);

    channels = 4'd4;
    for (int i = 0; i < 5; i++) begin
      rxstrobe = 1'b1;
      tick();
      rxstrobe = 1'b0;
      tick();
    end
    repeat (4) tick();
    chk("burst_drop", drop_count, 3);
    chk("burst_ovr", overrun, 1);
    chk("burst_frames", frame_count, 4);
    chk("burst_empty", bus.out_valid, 0);

    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("clr_ovr", overrun, 0);
    chk("clr_drop", drop_count, 0);

    rxstrobe = 1'b1;
    tick();
    clear_status = 1'b1;
    tick();
    rxstrobe     = 1'b0;
    clear_status = 1'b0;
    chk("clrdrop_ovr", overrun, 1);
    chk("clrdrop_cnt", drop_count, 1);
    repeat (6) tick();
    chk("clrdrop_frames", frame_count, 5);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("clr2_drop", drop_count, 0);

    bus.out_ready = 1'b0;
    channels      = 4'd8;
    strobe();
    repeat (8) tick();
    chk("fill1_level", level, 8);
    chk("fill1_pkt", pkt_rdy, 0);
    strobe();
    repeat (4) tick();
    chk("fill2_level12", level, 12);
    chk("fill2_pkt_lag", pkt_rdy, 0);
    tick();
    chk("fill2_level13", level, 13);
    chk("fill2_pkt", pkt_rdy, 1);
    repeat (3) tick();
    strobe();
    repeat (8) tick();
    strobe();
    repeat (8) tick();
    chk("full_level", level, 32);
    strobe();
    chk("full_drop", drop_count, 1);
    chk("full_ovr", overrun, 1);
    chk("full_frames", frame_count, 9);
    chk("full_head", bus.out_data, ew(0));

    bus.out_ready = 1'b1;
    repeat (12) tick();
    bus.out_ready = 1'b0;
    chk("drain_level", level, 20);
    strobe();
    tick();
    tick();
    chk("mid_level", level, 22);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_data", bus.out_data, 0);
    chk("flush_pkt_lag", pkt_rdy, 1);
    tick();
    chk("flush_pkt", pkt_rdy, 0);
    repeat (8) tick();
    chk("flush_idle", level, 0);
    chk("flush_frames", frame_count, 10);
    chk("flush_drop", drop_count, 1);

    strobe();
    tick();
    tick();
    gate_enable = 1'b0;
    repeat (6) tick();
    chk("gate_level", level, 8);
    chk("gate_frames", frame_count, 11);
    strobe();
    tick();
    tick();
    chk("gate0_level", level, 8);
    chk("gate0_drop", drop_count, 1);
    chk("gate0_frames", frame_count, 11);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("gate_word", bus.out_data, ew(k));
      tick();
    end
    chk("gate_empty", bus.out_valid, 0);

    bus.out_ready = 1'b0;
    gate_enable   = 1'b1;
    strobe();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_data", bus.out_data, 0);
    chk("arst_pkt", pkt_rdy, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_drop", drop_count, 0);
    chk("arst_frames", frame_count, 0);
    tick();
    reset_n  = 1'b1;
    channels = 4'd4;
    strobe();
    repeat (4) tick();
    chk("post_level", level, 4);
    chk("post_head", bus.out_data, ew(0));
    chk("post_frames", frame_count, 1);
    repeat (2) tick();
    chk("post_stable", level, 4);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
